// File: rtl/sys_bus_responder.sv
// sys_bus_responder: system-bus peripheral with a 32-bit timer/compare unit,
// a transmit FIFO drained through a valid/ready port, and a scratch register.
// All registers share one address window; reads are returned one cycle late.
module sys_bus_responder #(
    parameter logic [31:0] BASE       = 32'h0001_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] w_addr,
    input  logic [31:0] r_addr,
    input  logic [31:0] w_line,
    input  logic        write,
    input  logic        read,
    output logic [31:0] r_line,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        irq
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [5:0] OFF_CNT     = 6'h00;
    localparam logic [5:0] OFF_CMP     = 6'h01;
    localparam logic [5:0] OFF_CTRL    = 6'h02;
    localparam logic [5:0] OFF_STATUS  = 6'h03;
    localparam logic [5:0] OFF_TXD     = 6'h04;
    localparam logic [5:0] OFF_SCRATCH = 6'h05;

    // Byte-lane bits of both addresses are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{w_addr[1:0], r_addr[1:0]};

    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   cmp_q, cmp_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic          match_q, match_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   scratch_q, scratch_d;
    logic [31:0]   r_line_q, r_line_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   mem [FIFO_DEPTH];

    logic          w_hit, r_hit;
    logic [5:0]    w_off, r_off;
    logic          fifo_full, fifo_empty;
    logic          push_req, push, pop;
    logic          cnt_eq;

    assign w_hit      = write && (w_addr[31:8] == BASE[31:8]);
    assign r_hit      = read  && (r_addr[31:8] == BASE[31:8]);
    assign w_off      = w_addr[7:2];
    assign r_off      = r_addr[7:2];
    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && out_ready;
    assign push_req   = w_hit && (w_off == OFF_TXD);
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push       = push_req && (!fifo_full || pop);
    assign cnt_eq     = (cnt_q == cmp_q);

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 32'h0 : mem[rd_ptr_q];
    assign irq       = ctrl_q[2] && match_q;
    assign r_line    = r_line_q;

    // Read mux: always sees pre-write register values, so a same-cycle
    // write to the read register is not visible until the following read.
    always_comb begin
        r_line_d = 32'h0;
        if (r_hit) begin
            case (r_off)
                OFF_CNT:     r_line_d = cnt_q;
                OFF_CMP:     r_line_d = cmp_q;
                OFF_CTRL:    r_line_d = {29'h0, ctrl_q};
                OFF_STATUS:  r_line_d = {23'h0, 5'(count_q), ovf_q,
                                         fifo_empty, fifo_full, match_q};
                OFF_SCRATCH: r_line_d = scratch_q;
                default:     r_line_d = 32'h0;
            endcase
        end
    end

    // Timer, control and status next-state: software writes to CNT win over
    // counting, and hardware set of MATCH/OVF wins over a coincident W1C.
    always_comb begin
        cnt_d     = cnt_q;
        cmp_d     = cmp_q;
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        match_d   = match_q;
        ovf_d     = ovf_q;

        if (ctrl_q[0]) begin
            if (cnt_eq && ctrl_q[1]) cnt_d = 32'h0;
            else                     cnt_d = cnt_q + 32'h1;
        end

        if (w_hit) begin
            case (w_off)
                OFF_CNT:     cnt_d     = w_line;
                OFF_CMP:     cmp_d     = w_line;
                OFF_CTRL:    ctrl_d    = w_line[2:0];
                OFF_SCRATCH: scratch_d = w_line;
                OFF_STATUS: begin
                    if (w_line[0]) match_d = 1'b0;
                    if (w_line[3]) ovf_d   = 1'b0;
                end
                default: ;
            endcase
        end

        if (ctrl_q[0] && cnt_eq)           match_d = 1'b1;
        if (push_req && fifo_full && !pop) ovf_d   = 1'b1;
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    // FIFO storage; contents need no reset because out_data is gated by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= w_line;
    end

    // State registers, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            cmp_q     <= '0;
            ctrl_q    <= '0;
            match_q   <= 1'b0;
            ovf_q     <= 1'b0;
            scratch_q <= '0;
            r_line_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            cmp_q     <= cmp_d;
            ctrl_q    <= ctrl_d;
            match_q   <= match_d;
            ovf_q     <= ovf_d;
            scratch_q <= scratch_d;
            r_line_q  <= r_line_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end
endmodule

// File: tb/tb_sys_bus_responder.sv
// Directed self-checking bench for sys_bus_responder.
module tb_sys_bus_responder;
    localparam logic [31:0] B = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] w_addr, r_addr, w_line;
    logic        write, read, out_ready;
    logic [31:0] r_line, out_data;
    logic        out_valid, irq;

    int checks = 0;
    int passed = 0;

    sys_bus_responder #(.BASE(B), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .w_addr(w_addr), .r_addr(r_addr),
        .w_line(w_line), .write(write), .read(read), .r_line(r_line),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        $display("check %-12s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        w_addr = a; w_line = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        r_addr = a; read = 1'b1;
        tick();
        read = 1'b0;
        chk(tag, r_line, exp);
    endtask

    logic [31:0] seq_reload [5];
    logic [31:0] seq_wrap [9];

    initial begin
        seq_reload = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        seq_wrap   = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2,
                       32'd3, 32'd4, 32'd5, 32'd6};
        rst = 1'b0; write = 1'b0; read = 1'b0; out_ready = 1'b0;
        w_addr = '0; r_addr = '0; w_line = '0;

        // Outputs during reset
        #12;
        chk("rst_rline", r_line, 32'h0);
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rst = 1'b1;
        tick();

        // Readback, status, decode misses
        wr(B + 32'h14, 32'hDEAD_BEEF);
        rd(B + 32'h14, 32'hDEAD_BEEF, "scratch");
        rd(B + 32'h0C, 32'h0000_0004, "status0");
        rd(B + 32'h100, 32'h0, "miss_rd");
        rd(B + 32'h18, 32'h0, "unmapped");
        rd(B + 32'h10, 32'h0, "txd_rd");
        chk("idle_rline", r_line, r_line);
        checks--; passed--;
        tick();
        chk("no_read_0", r_line, 32'h0);
        wr(B + 32'h114, 32'h5555_5555);
        // Same-cycle read and write of SCRATCH returns the old value
        w_addr = B + 32'h14; w_line = 32'h1234_5678; write = 1'b1;
        r_addr = B + 32'h14; read = 1'b1;
        tick();
        write = 1'b0; read = 1'b0;
        chk("rd_wr_same", r_line, 32'hDEAD_BEEF);
        rd(B + 32'h14, 32'h1234_5678, "scratch2");

        // Timer with reload: CNT 0,1,2,3,0; MATCH on the CNT==3 edge
        wr(B + 32'h04, 32'd3);
        wr(B + 32'h08, 32'd7);
        r_addr = B; read = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("reload%0d", i), r_line, seq_reload[i]);
            if (i == 2) chk("irq_pre", {31'h0, irq}, 32'h0);
            if (i == 3) chk("irq_rise", {31'h0, irq}, 32'h1);
        end
        read = 1'b0;
        wr(B + 32'h0C, 32'h1);
        chk("irq_clr", {31'h0, irq}, 32'h0);
        wr(B + 32'h08, 32'h0);
        chk("irq_off", {31'h0, irq}, 32'h0);

        // Timer without reload, wrapping through zero
        wr(B, 32'hFFFF_FFFE);
        wr(B + 32'h04, 32'd5);
        wr(B + 32'h08, 32'd1);
        r_addr = B; read = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("wrap%0d", i), r_line, seq_wrap[i]);
        end
        read = 1'b0;
        chk("irq_ie0", {31'h0, irq}, 32'h0);
        wr(B + 32'h08, 32'h0);
        rd(B + 32'h0C, 32'h0000_0005, "st_match");
        wr(B + 32'h0C, 32'h1);
        rd(B + 32'h0C, 32'h0000_0004, "st_clr");

        // FIFO fill and overflow
        for (int i = 0; i < 5; i++) wr(B + 32'h10, 32'hA0 + i);
        rd(B + 32'h0C, 32'h0000_004A, "st_full");
        chk("head_A0", out_data, 32'hA0);
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("drainA%0d", i), out_data, 32'hA0 + i);
        end
        tick();
        chk("emptyA_v", {31'h0, out_valid}, 32'h0);
        chk("emptyA_d", out_data, 32'h0);
        out_ready = 1'b0;
        wr(B + 32'h0C, 32'h8);
        rd(B + 32'h0C, 32'h0000_0004, "ovf_clr");

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 4; i++) wr(B + 32'h10, 32'hB0 + i);
        out_ready = 1'b1;
        wr(B + 32'h10, 32'hB4);
        out_ready = 1'b0;
        rd(B + 32'h0C, 32'h0000_0042, "st_pushpop");
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("drainB%0d", i), out_data, 32'hB0 + i);
            tick();
        end
        chk("emptyB_v", {31'h0, out_valid}, 32'h0);
        out_ready = 1'b0;

        // Asynchronous reset mid-operation
        wr(B + 32'h04, 32'h0);
        wr(B, 32'h0);
        wr(B + 32'h08, 32'd7);
        wr(B + 32'h10, 32'hC0);
        wr(B + 32'h10, 32'hC1);
        rd(B + 32'h14, 32'h1234_5678, "pre_rst_rd");
        r_addr = B + 32'h14; read = 1'b1;
        tick();
        read = 1'b0;
        chk("pre_irq", {31'h0, irq}, 32'h1);
        chk("pre_valid", {31'h0, out_valid}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("ar_valid", {31'h0, out_valid}, 32'h0);
        chk("ar_irq", {31'h0, irq}, 32'h0);
        chk("ar_rline", r_line, 32'h0);
        #1 rst = 1'b1;
        tick();
        rd(B, 32'h0, "cnt_after");
        rd(B + 32'h0C, 32'h0000_0004, "st_after");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
